// File: rtl/burst_trigger_sequencer_pkg.sv
// ============================================================================
// Module   : burst_trigger_sequencer_pkg
// Purpose  : Shared state encoding and constants for the burst trigger
//            sequencer.
// Contents : state_e  - 2-bit FSM state encoding (IDLE, FIRE, WAIT, DONE)
//            MIN_PERIOD - smallest pulse spacing the sequencer will use
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package burst_trigger_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Spacing of 2 keeps at least one low cycle between trig_o pulses so the
  // downstream edge detector sees every pulse.
  localparam int unsigned MIN_PERIOD = 2;

endpackage

`default_nettype wire

// File: rtl/burst_trigger_sequencer_edge_detector_sync.sv
// ============================================================================
// Module   : edge_detector_sync
// Purpose  : Rising-edge detector on a synchronous level input.
// Ports    : clk_i - clock
//            rst_i - synchronous active-high reset
//            d_i   - level input (already in the clk_i domain)
//            pe_o  - high while d_i=1 and d_i was 0 at the previous edge
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detector_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pe_o
);

  logic r_hist;

  // History resets to 1 so an input held high through reset is not an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hist <= 1'b1;
    end else begin
      r_hist <= d_i;
    end
  end

  assign pe_o = d_i & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/burst_trigger_sequencer.sv
// ============================================================================
// Module   : burst_trigger_sequencer
// Purpose  : On a rising edge of start_i, emits n_pulses_i one-cycle trig_o
//            pulses spaced max(period_i, 2) cycles apart.
// Ports    : clk_i       - clock
//            rst_i       - synchronous active-high reset
//            start_i     - level; rising edge launches a burst (IDLE only)
//            abort_i     - synchronous level abort
//            period_i    - pulse spacing, latched at launch
//            n_pulses_i  - pulses per burst, latched at launch
//            trig_o      - registered one-cycle trigger
//            busy_o      - burst in progress
//            done_o      - one-cycle pulse on normal completion
//            pulse_idx_o - 0-based index of the most recent trig_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_trigger_sequencer
  import burst_trigger_sequencer_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic [COUNT_WIDTH-1:0]  n_pulses_i,
  output logic                    trig_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [COUNT_WIDTH-1:0]  pulse_idx_o
);

  state_e                  r_state;
  logic                    r_trig;
  logic                    r_busy;
  logic                    r_done;
  logic [COUNT_WIDTH-1:0]  r_idx;
  logic [PERIOD_WIDTH-1:0] r_pcnt;
  logic [PERIOD_WIDTH-1:0] r_wait_last;
  logic [COUNT_WIDTH-1:0]  r_n;

  state_e                  w_state_next;
  logic                    w_trig_next;
  logic                    w_busy_next;
  logic                    w_done_next;
  logic [COUNT_WIDTH-1:0]  w_idx_next;
  logic [PERIOD_WIDTH-1:0] w_pcnt_next;
  logic [PERIOD_WIDTH-1:0] w_wait_last_next;
  logic [COUNT_WIDTH-1:0]  w_n_next;
  logic                    w_launch;
  logic [PERIOD_WIDTH-1:0] w_period_eff;

  edge_detector_sync u_start_edge (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (start_i),
    .pe_o  (w_launch)
  );

  assign w_period_eff = (period_i < PERIOD_WIDTH'(MIN_PERIOD)) ?
                        PERIOD_WIDTH'(MIN_PERIOD) : period_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_trig      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_idx       <= '0;
      r_pcnt      <= '0;
      r_wait_last <= '0;
      r_n         <= '0;
    end else begin
      r_state     <= w_state_next;
      r_trig      <= w_trig_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_idx       <= w_idx_next;
      r_pcnt      <= w_pcnt_next;
      r_wait_last <= w_wait_last_next;
      r_n         <= w_n_next;
    end
  end

  // Output registers hold the value for the state being entered, so every
  // output lines up exactly with the cycle its state occupies.
  always_comb begin
    w_state_next     = r_state;
    w_trig_next      = 1'b0;
    w_busy_next      = 1'b0;
    w_done_next      = 1'b0;
    w_idx_next       = r_idx;
    w_pcnt_next      = r_pcnt;
    w_wait_last_next = r_wait_last;
    w_n_next         = r_n;

    case (r_state)
      IDLE, DONE: begin
        w_state_next = IDLE;
        if (w_launch) begin
          // WAIT lasts P-1 cycles: the counter runs 0 .. P-2.
          w_wait_last_next = w_period_eff - PERIOD_WIDTH'(MIN_PERIOD);
          w_n_next         = n_pulses_i;
          w_pcnt_next      = '0;
          if (n_pulses_i == '0) begin
            w_state_next = DONE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = FIRE;
            w_trig_next  = 1'b1;
            w_busy_next  = 1'b1;
            w_idx_next   = '0;
          end
        end
      end

      FIRE: begin
        w_state_next = WAIT;
        w_busy_next  = 1'b1;
        w_pcnt_next  = '0;
      end

      WAIT: begin
        w_busy_next = 1'b1;
        if (r_pcnt == r_wait_last) begin
          w_pcnt_next = '0;
          // r_n is non-zero here; r_idx never exceeds r_n-1, so no wrap.
          if (r_idx == r_n - COUNT_WIDTH'(1)) begin
            w_state_next = DONE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = FIRE;
            w_trig_next  = 1'b1;
            w_idx_next   = r_idx + COUNT_WIDTH'(1);
          end
        end else begin
          w_pcnt_next = r_pcnt + PERIOD_WIDTH'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Abort wins over everything, including a launch seen in IDLE.
    if (abort_i) begin
      w_state_next = IDLE;
      w_trig_next  = 1'b0;
      w_busy_next  = 1'b0;
      w_done_next  = 1'b0;
      w_idx_next   = r_idx;
    end
  end

  assign trig_o      = r_trig;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pulse_idx_o = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_burst_trigger_sequencer.sv
// ============================================================================
// Module   : tb_burst_trigger_sequencer
// Purpose  : Self-checking bench for burst_trigger_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_burst_trigger_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [31:0] period_i;
  logic [15:0] n_pulses_i;
  logic        trig_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] pulse_idx_o;

  always #5 clk_i = ~clk_i;

  burst_trigger_sequencer #(
    .PERIOD_WIDTH (32),
    .COUNT_WIDTH  (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .period_i    (period_i),
    .n_pulses_i  (n_pulses_i),
    .trig_o      (trig_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pulse_idx_o (pulse_idx_o)
  );

  typedef struct packed {
    logic        trig;
    logic        busy;
    logic        done;
    logic [15:0] idx;
  } exp_t;

  // One burst record: input config plus hand-derived effective period.
  typedef struct {
    int unsigned period;
    int          n;
    bit          drive_cfg;
    int          exp_p;
    int          restart_at;
    int          abort_at;
    int          chg_at;
    int unsigned chg_period;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  logic [15:0] m_idx  = '0;
  vec_t        vecs[9];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic t, input logic b, input logic d, input logic [15:0] i);
    exp_t e;
    e.trig = t;
    e.busy = b;
    e.done = d;
    e.idx  = i;
    sb.push_back(e);
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    exp_t a;
    a.trig = trig_o;
    a.busy = busy_o;
    a.done = done_o;
    a.idx  = pulse_idx_o;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, actual trig=%0b busy=%0b done=%0b idx=%0d",
               name, a.trig, a.busy, a.done, a.idx);
    end else begin
      e = sb.pop_front();
      if (a === e) begin
        passed++;
      end else begin
        $display("FAIL %s: actual trig=%0b busy=%0b done=%0b idx=%0d, required trig=%0b busy=%0b done=%0b idx=%0d",
                 name, a.trig, a.busy, a.done, a.idx, e.trig, e.busy, e.done, e.idx);
      end
    end
  endtask

  task automatic expect_now(input string name, input logic t, input logic b,
                            input logic d, input logic [15:0] i);
    push_exp(t, b, d, i);
    check_pop(name);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int  p;
    int  n;
    int  tlen;
    bit  active;
    bit  tr;
    p    = v.exp_p;
    n    = v.n;
    tlen = n * p + 3;
    if (v.drive_cfg) begin
      period_i   = v.period;
      n_pulses_i = 16'(v.n);
    end
    start_i = 1'b1;
    // Expected timeline relative to launch edge k: cycle k+t, t >= 1.
    for (int t = 1; t <= tlen; t++) begin
      active = (v.abort_at < 0) || (t <= v.abort_at);
      tr     = active && ((t - 1) % p == 0) && ((t - 1) / p < n);
      if (tr) m_idx = 16'((t - 1) / p);
      push_exp(tr, active && (t <= n * p), active && (t == n * p + 1), m_idx);
    end
    step();
    for (int t = 1; t <= tlen; t++) begin
      check_pop($sformatf("v%0d_t%0d", id, t));
      start_i = (t == v.restart_at);
      abort_i = (t == v.abort_at);
      if (t == v.chg_at) period_i = v.chg_period;
      step();
    end
  endtask

  initial begin
    //          period n  drv  p  restart abort chg  chg_period
    vecs[0] = '{5,     3, 1'b1, 5, -1,     -1,   -1,  0};
    vecs[1] = '{0,     2, 1'b1, 2, -1,     -1,   -1,  0};
    vecs[2] = '{7,     0, 1'b1, 2, -1,     -1,   -1,  0};
    vecs[3] = '{5,     3, 1'b1, 5, 4,      -1,   -1,  0};
    vecs[4] = '{5,     3, 1'b1, 5, -1,     -1,   2,   9};
    vecs[5] = '{0,     3, 1'b0, 9, -1,     -1,   -1,  0};
    vecs[6] = '{5,     3, 1'b1, 5, -1,     7,    -1,  0};
    vecs[7] = '{1,     4, 1'b1, 2, -1,     -1,   -1,  0};
    vecs[8] = '{3,     1, 1'b1, 3, -1,     -1,   -1,  0};

    rst_i      = 1'b1;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    period_i   = 32'd5;
    n_pulses_i = 16'd3;
    step();
    expect_now("reset_a", 1'b0, 1'b0, 1'b0, 16'd0);
    step();
    expect_now("reset_b", 1'b0, 1'b0, 1'b0, 16'd0);
    rst_i = 1'b0;
    step();
    step();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end

    // Abort and start rise on the same edge in IDLE: no launch, ever.
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    expect_now("abort_idle_0", 1'b0, 1'b0, 1'b0, m_idx);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_now($sformatf("abort_idle_%0d", i), 1'b0, 1'b0, 1'b0, m_idx);
    end
    start_i = 1'b0;
    step();

    // start_i held high through reset: no launch until it falls and rises.
    period_i   = 32'd4;
    n_pulses_i = 16'd3;
    start_i    = 1'b1;
    rst_i      = 1'b1;
    step();
    rst_i = 1'b0;
    m_idx = '0;
    expect_now("rst_hold_0", 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_now($sformatf("rst_hold_%0d", i), 1'b0, 1'b0, 1'b0, 16'd0);
    end
    start_i = 1'b0;
    step();
    expect_now("rst_hold_low", 1'b0, 1'b0, 1'b0, 16'd0);
    start_i = 1'b1;
    step();
    expect_now("relaunch_t1", 1'b1, 1'b1, 1'b0, 16'd0);
    start_i = 1'b0;
    step();
    expect_now("relaunch_t2", 1'b0, 1'b1, 1'b0, 16'd0);

    // Reset mid-burst: everything clears, no done_o afterwards.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    expect_now("rst_mid_0", 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      expect_now($sformatf("rst_mid_%0d", i), 1'b0, 1'b0, 1'b0, 16'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
